palette_scheduler: RTL and testbench

PALETTE_SCHEDULER -- requirements
Module: palette_scheduler

---
 rtl/palette_scheduler.sv | 107 ++++++++++
 tb/tb_palette_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/palette_scheduler.sv
// Palette select scheduler: defers palette changes to the vblank frame tick and,
// when PALETTE_FLASH_EN is defined, runs a multi-frame flash against the base palette.
module palette_scheduler #(
  parameter int unsigned VBLANK_LINE = 480,
  parameter logic [2:0]  FLASH_PAL   = 3'b010,
  parameter logic [2:0]  RESET_PAL   = 3'b001
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] drawY,
  input  logic       req_valid,
  input  logic [2:0] req_pal,
  output logic       req_ready,
  input  logic       flash_start,
  input  logic [3:0] flash_frames,
  output logic [2:0] palSelect,
  output logic       frame_tick,
  output logic       busy
);

  localparam logic [9:0] VblankY = 10'(VBLANK_LINE);

`ifdef PALETTE_FLASH_EN
  typedef enum logic [1:0] {StIdle, StPending, StFlash} state_t;
`else
  typedef enum logic [0:0] {StIdle, StPending} state_t;
`endif

  state_t     state;
  logic [9:0] drawY_prev;
  logic [2:0] base_pal;
  logic [2:0] pend_pal;
  logic [2:0] req_pal_coerced;
  logic       vblank_edge;

`ifdef PALETTE_FLASH_EN
  logic [3:0] flash_cnt;
  logic       flash_on;  // palSelect currently shows FLASH_PAL
`else
  logic unused_flash;
  assign unused_flash = ^{flash_start, flash_frames, base_pal};
`endif

  assign vblank_edge     = (drawY == VblankY) && (drawY_prev != VblankY);
  assign req_pal_coerced = (req_pal > 3'b010) ? 3'b000 : req_pal;
  assign req_ready       = (state == StIdle);
  assign busy            = (state != StIdle);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= StIdle;
      palSelect  <= RESET_PAL;
      base_pal   <= RESET_PAL;
      pend_pal   <= 3'b000;
      frame_tick <= 1'b0;
      drawY_prev <= 10'd0;
`ifdef PALETTE_FLASH_EN
      flash_cnt  <= 4'd0;
      flash_on   <= 1'b0;
`endif
    end else begin
      drawY_prev <= drawY;
      frame_tick <= vblank_edge;
      unique case (state)
        StIdle: begin
          // A request wins over a simultaneous flash command.
          if (req_valid) begin
            pend_pal <= req_pal_coerced;
            state    <= StPending;
          end
`ifdef PALETTE_FLASH_EN
          else if (flash_start && (flash_frames != 4'd0)) begin
            flash_cnt <= flash_frames;
            flash_on  <= 1'b0;
            state     <= StFlash;
          end
`endif
        end
        StPending: begin
          if (frame_tick) begin
            palSelect <= pend_pal;
            base_pal  <= pend_pal;
            state     <= StIdle;
          end
        end
`ifdef PALETTE_FLASH_EN
        StFlash: begin
          if (frame_tick) begin
            if (flash_cnt == 4'd1) begin
              palSelect <= base_pal;
              flash_cnt <= 4'd0;
              flash_on  <= 1'b0;
              state     <= StIdle;
            end else begin
              palSelect <= flash_on ? base_pal : FLASH_PAL;
              flash_on  <= ~flash_on;
              flash_cnt <= flash_cnt - 4'd1;
            end
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_palette_scheduler.sv
// Self-checking bench for palette_scheduler: vector table, directed corner cases and
// randomized frame sweeps against a per-frame palette schedule model.
module tb_palette_scheduler;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] drawY;
  logic       req_valid;
  logic [2:0] req_pal;
  logic       req_ready;
  logic       flash_start;
  logic [3:0] flash_frames;
  logic [2:0] palSelect;
  logic       frame_tick;
  logic       busy;

  int checks = 0;
  int errors = 0;

  palette_scheduler dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .drawY        (drawY),
    .req_valid    (req_valid),
    .req_pal      (req_pal),
    .req_ready    (req_ready),
    .flash_start  (flash_start),
    .flash_frames (flash_frames),
    .palSelect    (palSelect),
    .frame_tick   (frame_tick),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  // Model: a queue of palette values, one consumed per frame tick.
  typedef struct packed {logic is_req; logic [2:0] pal;} ent_t;
  ent_t       m_q[$];
  logic [2:0] m_pal;
  logic [2:0] m_base;
  logic       m_tick;
  logic [9:0] m_prev;

  typedef struct {
    logic [9:0] y;
    logic       rv;
    logic [2:0] rp;
    logic       fs;
    logic [3:0] ff;
    logic [2:0] e_pal;
    logic       e_tick;
    logic       e_busy;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pal  = 3'b001;
    m_base = 3'b001;
    m_tick = 1'b0;
    m_prev = 10'd0;
  endtask

  task automatic step(input logic [9:0] y, input logic rv, input logic [2:0] rp,
                      input logic fs, input logic [3:0] ff);
    ent_t e;
    drawY        = y;
    req_valid    = rv;
    req_pal      = rp;
    flash_start  = fs;
    flash_frames = ff;
    @(posedge Clk);
    if (m_tick && m_q.size() > 0) begin
      e     = m_q.pop_front();
      m_pal = e.pal;
      if (e.is_req) m_base = e.pal;
    end else if (m_q.size() == 0) begin
      if (rv) begin
        e.is_req = 1'b1;
        e.pal    = (rp > 3'd2) ? 3'd0 : rp;
        m_q.push_back(e);
      end
`ifdef PALETTE_FLASH_EN
      else if (fs && ff != 4'd0) begin
        for (int i = 0; i < int'(ff); i++) begin
          e.is_req = 1'b0;
          e.pal    = (i == int'(ff) - 1 || i % 2 == 1) ? m_base : 3'b010;
          m_q.push_back(e);
        end
      end
`endif
    end
    m_tick = (y == 10'd480) && (m_prev != 10'd480);
    m_prev = y;
    #1;
    check("palSelect", int'(palSelect), int'(m_pal));
    check("frame_tick", int'(frame_tick), int'(m_tick));
    check("busy", int'(busy), int'(m_q.size() > 0));
    check("req_ready", int'(req_ready), int'(m_q.size() == 0));
  endtask

  task automatic frame_boundary();
    step(10'd479, 1'b0, 3'd0, 1'b0, 4'd0);
    step(10'd480, 1'b0, 3'd0, 1'b0, 4'd0);
    step(10'd481, 1'b0, 3'd0, 1'b0, 4'd0);
  endtask

  initial begin
    Reset        = 1'b1;
    drawY        = 10'd0;
    req_valid    = 1'b0;
    req_pal      = 3'd0;
    flash_start  = 1'b0;
    flash_frames = 4'd0;
    model_reset();

    vecs[0]  = '{10'd100, 1'b1, 3'd2, 1'b0, 4'd0, 3'd1, 1'b0, 1'b1};
    vecs[1]  = '{10'd478, 1'b0, 3'd0, 1'b0, 4'd0, 3'd1, 1'b0, 1'b1};
    vecs[2]  = '{10'd479, 1'b0, 3'd0, 1'b0, 4'd0, 3'd1, 1'b0, 1'b1};
    vecs[3]  = '{10'd480, 1'b0, 3'd0, 1'b0, 4'd0, 3'd1, 1'b1, 1'b1};
    vecs[4]  = '{10'd480, 1'b0, 3'd0, 1'b0, 4'd0, 3'd2, 1'b0, 1'b0};
    vecs[5]  = '{10'd481, 1'b0, 3'd0, 1'b0, 4'd0, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{10'd100, 1'b1, 3'd6, 1'b0, 4'd0, 3'd2, 1'b0, 1'b1};
    vecs[7]  = '{10'd480, 1'b0, 3'd0, 1'b0, 4'd0, 3'd2, 1'b1, 1'b1};
    vecs[8]  = '{10'd481, 1'b0, 3'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{10'd200, 1'b1, 3'd1, 1'b1, 4'd3, 3'd0, 1'b0, 1'b1};
    vecs[10] = '{10'd480, 1'b0, 3'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b1};
    vecs[11] = '{10'd0,   1'b0, 3'd0, 1'b0, 4'd0, 3'd1, 1'b0, 1'b0};

    #3;
    check("reset palSelect", int'(palSelect), 1);
    check("reset req_ready", int'(req_ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset frame_tick", int'(frame_tick), 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].y, vecs[i].rv, vecs[i].rp, vecs[i].fs, vecs[i].ff);
      check($sformatf("vec%0d palSelect", i), int'(palSelect), int'(vecs[i].e_pal));
      check($sformatf("vec%0d frame_tick", i), int'(frame_tick), int'(vecs[i].e_tick));
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].e_busy));
    end

    // Reset while a change is pending discards it.
    step(10'd100, 1'b1, 3'd2, 1'b0, 4'd0);
    check("pend busy", int'(busy), 1);
    Reset = 1'b1;
    #1;
    check("async reset palSelect", int'(palSelect), 1);
    check("async reset busy", int'(busy), 0);
    check("async reset req_ready", int'(req_ready), 1);
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    frame_boundary();
    check("no commit after reset", int'(palSelect), 1);

`ifdef PALETTE_FLASH_EN
    step(10'd100, 1'b0, 3'd0, 1'b1, 4'd3);
    check("flash busy", int'(busy), 1);
    frame_boundary();
    check("flash tick1", int'(palSelect), 2);
    frame_boundary();
    check("flash tick2", int'(palSelect), 1);
    frame_boundary();
    check("flash tick3", int'(palSelect), 1);
    check("flash done busy", int'(busy), 0);
    step(10'd100, 1'b0, 3'd0, 1'b1, 4'd0);
    check("flash zero ignored", int'(busy), 0);
`else
    step(10'd100, 1'b0, 3'd0, 1'b1, 4'd3);
    check("flash ignored busy", int'(busy), 0);
    frame_boundary();
    check("flash ignored pal", int'(palSelect), 1);
`endif

    // Randomized full-frame sweeps.
    for (int f = 0; f < 15; f++) begin
      for (int y = 0; y < 525; y++) begin
        step(10'(y), ($urandom_range(0, 149) == 0), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 199) == 0), 4'($urandom_range(0, 5)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
